// File: rtl/booth_mul_sched_if.sv
// Bundle of requester, response and BoothMul-side signals for booth_mul_sched.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface booth_mul_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [2:0]        resp_id;
    logic [7:0]        resp_data;
    logic              resp_err;
    logic              busy;
    logic              mul_start;
    logic [3:0]        mul_x;
    logic [3:0]        mul_y;
    logic              mul_valid;
    logic [7:0]        mul_z;

    modport master (
        output req_valid, req_a, req_b, resp_ready, mul_valid, mul_z,
        input  req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
               mul_start, mul_x, mul_y
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, mul_valid, mul_z,
        output req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
               mul_start, mul_x, mul_y
    );
endinterface

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one 4x4 signed Booth multiplier among NREQ
// requesters, with a watchdog that aborts a transaction the multiplier never answers.
module booth_mul_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    booth_mul_sched_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state, w_state;
    logic [2:0]        r_last, w_last;
    logic [2:0]        r_id, w_id;
    logic [WD_W-1:0]   r_wdog, w_wdog;
    logic [NREQ-1:0]   r_req_ready, w_req_ready;
    logic              r_mul_start, w_mul_start;
    logic [3:0]        r_mul_x, w_mul_x;
    logic [3:0]        r_mul_y, w_mul_y;
    logic              r_resp_valid, w_resp_valid;
    logic [7:0]        r_resp_data, w_resp_data;
    logic              r_resp_err, w_resp_err;
    logic              r_busy, w_busy;

    logic [2:0]        w_winner;
    logic              w_found;
    logic [2:0]        w_hi, w_lo;
    logic              w_hi_found;
    logic [3:0]        w_sel_a, w_sel_b;

    // Rotating priority: the lowest requester above last_grant wins, otherwise
    // the search wraps to the lowest requester overall.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        w_found    = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_lo    = 3'(i);
                w_found = 1'b1;
                if (i > int'(r_last)) begin
                    w_hi       = 3'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_winner = w_hi_found ? w_hi : w_lo;
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == w_winner) begin
                w_sel_a = bus.req_a[4*i +: 4];
                w_sel_b = bus.req_b[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_state      = r_state;
        w_last       = r_last;
        w_id         = r_id;
        w_wdog       = r_wdog;
        w_req_ready  = '0;
        w_mul_start  = 1'b0;
        w_mul_x      = r_mul_x;
        w_mul_y      = r_mul_y;
        w_resp_valid = r_resp_valid;
        w_resp_data  = r_resp_data;
        w_resp_err   = r_resp_err;

        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    for (int i = 0; i < NREQ; i++) begin
                        w_req_ready[i] = (3'(i) == w_winner);
                    end
                    w_mul_start = 1'b1;
                    w_mul_x     = w_sel_a;
                    w_mul_y     = w_sel_b;
                    w_id        = w_winner;
                    w_state     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_wdog  = '0;
                w_state = S_WAIT;
            end
            S_WAIT: begin
                // A product arriving on the last watchdog cycle still counts.
                if (bus.mul_valid) begin
                    w_resp_data  = bus.mul_z;
                    w_resp_err   = 1'b0;
                    w_resp_valid = 1'b1;
                    w_state      = S_RESP;
                end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                    w_resp_data  = '0;
                    w_resp_err   = 1'b1;
                    w_resp_valid = 1'b1;
                    w_state      = S_RESP;
                end else begin
                    w_wdog = r_wdog + WD_W'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_resp_valid = 1'b0;
                    w_last       = r_id;
                    w_state      = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_busy = (w_state != S_IDLE);
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values; the async reset clears all of them, outputs included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last       <= 3'(NREQ - 1);
            r_id         <= '0;
            r_wdog       <= '0;
            r_req_ready  <= '0;
            r_mul_start  <= 1'b0;
            r_mul_x      <= '0;
            r_mul_y      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_last       <= w_last;
            r_id         <= w_id;
            r_wdog       <= w_wdog;
            r_req_ready  <= w_req_ready;
            r_mul_start  <= w_mul_start;
            r_mul_x      <= w_mul_x;
            r_mul_y      <= w_mul_y;
            r_resp_valid <= w_resp_valid;
            r_resp_data  <= w_resp_data;
            r_resp_err   <= w_resp_err;
            r_busy       <= w_busy;
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.mul_start  = r_mul_start;
    assign bus.mul_x      = r_mul_x;
    assign bus.mul_y      = r_mul_y;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_id;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched: plays the four requesters, the response
// consumer and a BoothMul stub answering five cycles after mul_start.
module tb_booth_mul_sched;
    logic clk;
    logic rst;
    logic stub_en;
    int   n_checks = 0;
    int   n_err    = 0;

    booth_mul_sched_if #(.NREQ(4)) bus ();

    booth_mul_sched #(.NREQ(4), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // BoothMul stub: valid is high in the cycle after E5 when start was high after E0.
    initial begin
        logic signed [7:0] sx, sy;
        bus.mul_valid = 1'b0;
        bus.mul_z     = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.mul_start === 1'b1 && stub_en) begin
                repeat (5) @(posedge clk);
                #1;
                sx = {{4{bus.mul_x[3]}}, bus.mul_x};
                sy = {{4{bus.mul_y[3]}}, bus.mul_y};
                bus.mul_valid = 1'b1;
                bus.mul_z     = sx * sy;
                @(posedge clk); #1;
                bus.mul_valid = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_phase(input int exp_id);
        int n = 0;
        while (bus.req_ready == '0 && n < 40) begin
            tick();
            n++;
        end
        check("grant_onehot", 32'(bus.req_ready), 32'(1 << exp_id));
        check("grant_start", 32'(bus.mul_start), 32'd1);
    endtask

    task automatic resp_phase(input logic [7:0] exp_data, input logic exp_err,
                              input int exp_id, input int exp_lat);
        int n       = 0;
        bit overlap = 1'b0;
        while (bus.resp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (bus.req_ready != '0) overlap = 1'b1;
        end
        check("resp_latency", 32'(n), 32'(exp_lat));
        check("resp_data", 32'(bus.resp_data), 32'(exp_data));
        check("resp_id", 32'(bus.resp_id), 32'(exp_id));
        check("resp_err", 32'(bus.resp_err), 32'(exp_err));
        check("resp_busy", 32'(bus.busy), 32'd1);
        check("no_grant_while_busy", 32'(overlap), 32'd0);
    endtask

    initial begin
        bit stable;
        rst            = 1'b0;
        stub_en        = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        // req0 3*-2, req1 -3*4, req2 -8*-8, req3 7*-7
        bus.req_a      = {4'h7, 4'h8, 4'hD, 4'h3};
        bus.req_b      = {4'h9, 4'h8, 4'h4, 4'hE};

        // Reset state
        repeat (3) tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mul_start", 32'(bus.mul_start), 32'd0);
        check("rst_resp_data", 32'(bus.resp_data), 32'd0);
        rst = 1'b1;
        tick();

        // Single request from requester 0
        bus.resp_ready = 1'b1;
        bus.req_valid  = 4'b0001;
        grant_phase(0);
        check("t1_mul_x", 32'(bus.mul_x), 32'h3);
        check("t1_mul_y", 32'(bus.mul_y), 32'hE);
        check("t1_busy", 32'(bus.busy), 32'd1);
        bus.req_valid = 4'b0000;
        tick();
        check("t1_ready_pulse", 32'(bus.req_ready), 32'd0);
        check("t1_start_pulse", 32'(bus.mul_start), 32'd0);
        check("t1_x_held", 32'(bus.mul_x), 32'h3);
        resp_phase(8'hFA, 1'b0, 0, 5);
        tick();
        check("t1_resp_done", 32'(bus.resp_valid), 32'd0);
        check("t1_idle", 32'(bus.busy), 32'd0);

        // All four requesting; last grant was 0 so rotation starts at 1
        bus.req_valid = 4'b1111;
        grant_phase(1); resp_phase(8'hF4, 1'b0, 1, 6);
        grant_phase(2); resp_phase(8'h40, 1'b0, 2, 6);
        grant_phase(3); resp_phase(8'hCF, 1'b0, 3, 6);
        grant_phase(0); resp_phase(8'h0F - 8'h15, 1'b0, 0, 6);
        grant_phase(1); resp_phase(8'hF4, 1'b0, 1, 6);
        bus.req_valid = 4'b0000;
        tick();

        // Extreme operands on requester 2: -8 * 7
        bus.req_a[8 +: 4] = 4'h8;
        bus.req_b[8 +: 4] = 4'h7;
        bus.req_valid     = 4'b0100;
        grant_phase(2);
        bus.req_valid = 4'b0000;
        resp_phase(8'hC8, 1'b0, 2, 6);
        tick();

        // Consumer stalls for 10 cycles in RESP while requester 1 waits
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0001;
        grant_phase(0);
        bus.req_valid = 4'b0010;
        resp_phase(8'hFA, 1'b0, 0, 6);
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'hFA || bus.resp_id !== 3'd0 ||
                bus.req_ready !== 4'b0000 || bus.busy !== 1'b1)
                stable = 1'b0;
        end
        check("t4_stall_stable", 32'(stable), 32'd1);
        check("t4_still_valid", 32'(bus.resp_valid), 32'd1);

        // Multiplier never answers: watchdog aborts after TIMEOUT cycles in WAIT
        stub_en        = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        check("t4_released", 32'(bus.resp_valid), 32'd0);
        grant_phase(1);
        resp_phase(8'h00, 1'b1, 1, 16);
        stub_en       = 1'b1;
        bus.req_valid = 4'b0100;
        grant_phase(2);
        bus.req_valid = 4'b0000;
        resp_phase(8'hC8, 1'b0, 2, 6);
        tick();

        // Reset while waiting on requester 3, then requester 0 must win first
        bus.req_valid = 4'b1000;
        grant_phase(3);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("t6_rst_ready", 32'(bus.req_ready), 32'd0);
        check("t6_rst_start", 32'(bus.mul_start), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_valid", 32'(bus.resp_valid), 32'd0);
        check("t6_rst_x", 32'(bus.mul_x), 32'd0);
        check("t6_rst_y", 32'(bus.mul_y), 32'd0);
        bus.req_valid = 4'b1001;
        repeat (8) tick();
        rst = 1'b1;
        grant_phase(0);
        check("t6_x", 32'(bus.mul_x), 32'h3);
        bus.req_valid = 4'b1000;
        resp_phase(8'hFA, 1'b0, 0, 6);
        bus.req_valid = 4'b0000;
        tick();
        check("t6_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
